hub75_column_fetch: RTL and testbench

- Upstream feeder for the HUB75 output stage.
- On each new rotational sector (theta), reads that sector's 32 scan-line slices from the voxel column BRAM.
- Assembles each slice into two 9-plane x 64-pixel words, one for the upper panel half and one for the lower.
- Presents each slice to the HUB75 stage over a valid/ready/last stream, in order, one scan line per beat.

---
 rtl/hub75_pkg.sv | 35 +++
 rtl/hub75_read_tag_pipe.sv | 40 ++++
 rtl/hub75_column_fetch.sv | 201 ++++++++++++++++++++
 tb/tb_hub75_column_fetch.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | hub75_pkg: shared constants and types for the column fetcher   |
// | Revision: 1.0                                                  |
// +----------------------------------------------------------------+
package hub75_pkg;

  localparam int NUM_COLS       = 64;
  localparam int NUM_PLANES     = 9;
  localparam int SCAN_RATE      = 32;
  localparam int ROTATIONAL_RES = 180;

  localparam int THETA_BITS    = $clog2(ROTATIONAL_RES);
  localparam int ROW_BITS      = $clog2(SCAN_RATE);
  localparam int HALF_BITS     = 1;
  localparam int PLANE_BITS    = 4;
  localparam int ADDR_BITS     = THETA_BITS + ROW_BITS + HALF_BITS + PLANE_BITS;
  localparam int READS_PER_ROW = 2 * NUM_PLANES;

  typedef logic [NUM_PLANES-1:0][NUM_COLS-1:0] column_word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic                  valid;
    logic                  half;
    logic [PLANE_BITS-1:0] plane;
  } read_tag_t;

endpackage
`default_nettype wire

// File: rtl/hub75_read_tag_pipe.sv
`default_nettype none
// +----------------------------------------------------------------+
// | hub75_read_tag_pipe: carries {valid, half, plane} alongside    |
// | each BRAM read so the returning word lands in the right slot.  |
// | Revision: 1.0                                                  |
// +----------------------------------------------------------------+
module hub75_read_tag_pipe
  import hub75_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic      clk_in,
  input  logic      rst_in,
  input  read_tag_t tag_in,
  output read_tag_t tag_out
);

  read_tag_t [LATENCY-1:0] pipe_q;
  read_tag_t [LATENCY-1:0] pipe_d;

  always_comb begin
    pipe_d[0] = tag_in;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Clearing on reset makes any read still in flight vanish.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign tag_out = pipe_q[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/hub75_column_fetch.sv
`default_nettype none
// +----------------------------------------------------------------+
// | hub75_column_fetch: reads the 32 scan-line slices of a theta   |
// | sector from BRAM and streams them to the HUB75 output stage.   |
// | Revision: 1.0                                                  |
// +----------------------------------------------------------------+
module hub75_column_fetch
  import hub75_pkg::*;
#(
  parameter int BRAM_LATENCY = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [THETA_BITS-1:0] theta_in,
  input  logic                  theta_valid,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic                  mem_en,
  input  logic [NUM_COLS-1:0]   mem_rdata,
  output column_word_t          column_data0,
  output column_word_t          column_data1,
  output logic [ROW_BITS-1:0]   col_index,
  output logic                  tvalid,
  input  logic                  tready,
  output logic                  tlast,
  output logic                  busy,
  output logic [7:0]            drop_count,
  output logic                  theta_err
);

  localparam int ISSUE_BITS = $clog2(READS_PER_ROW + 1);

  fetch_state_t          state_q, state_d;
  logic [THETA_BITS-1:0] theta_q, theta_d;
  logic [THETA_BITS-1:0] pend_theta_q, pend_theta_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [ROW_BITS-1:0]   row_q, row_d;
  logic [ISSUE_BITS-1:0] issue_cnt_q, issue_cnt_d;
  logic [7:0]            drop_count_q, drop_count_d;
  logic                  theta_err_q, theta_err_d;
  column_word_t          col0_q, col0_d, col1_q, col1_d;

  logic                  issue_half;
  logic [PLANE_BITS-1:0] issue_plane;
  logic                  theta_ok;
  logic                  handshake;
  logic                  last_row;
  logic                  sector_done;
  logic                  fetch_done;
  logic                  drop_now;
  read_tag_t             tag_in, tag_out;

  // Read sequence: half 0 planes 0..8, then half 1 planes 0..8.
  always_comb begin
    mem_en      = (state_q == FETCH) && (issue_cnt_q < ISSUE_BITS'(READS_PER_ROW));
    issue_half  = (issue_cnt_q >= ISSUE_BITS'(NUM_PLANES));
    issue_plane = issue_half ? PLANE_BITS'(issue_cnt_q - ISSUE_BITS'(NUM_PLANES))
                             : PLANE_BITS'(issue_cnt_q);
    mem_addr      = mem_en ? {theta_q, row_q, issue_half, issue_plane} : '0;
    tag_in.valid  = mem_en;
    tag_in.half   = issue_half;
    tag_in.plane  = issue_plane;
  end

  hub75_read_tag_pipe #(
    .LATENCY (BRAM_LATENCY)
  ) u_tag_pipe (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign tvalid       = (state_q == PRESENT);
  assign tlast        = tvalid && last_row;
  assign busy         = (state_q != IDLE);
  assign col_index    = row_q;
  assign column_data0 = col0_q;
  assign column_data1 = col1_q;
  assign drop_count   = drop_count_q;
  assign theta_err    = theta_err_q;

  assign theta_ok    = theta_valid && (theta_in < THETA_BITS'(ROTATIONAL_RES));
  assign handshake   = tvalid && tready;
  assign last_row    = (row_q == ROW_BITS'(SCAN_RATE - 1));
  assign sector_done = handshake && last_row;
  assign fetch_done  = tag_out.valid && tag_out.half &&
                       (tag_out.plane == PLANE_BITS'(NUM_PLANES - 1));

  always_comb begin
    state_d      = state_q;
    theta_d      = theta_q;
    pend_theta_d = pend_theta_q;
    pend_valid_d = pend_valid_q;
    row_d        = row_q;
    issue_cnt_d  = issue_cnt_q;
    theta_err_d  = theta_err_q;
    col0_d       = col0_q;
    col1_d       = col1_q;
    drop_now     = 1'b0;

    if (theta_valid && !theta_ok) begin
      theta_err_d = 1'b1;
    end

    if (mem_en) begin
      issue_cnt_d = issue_cnt_q + ISSUE_BITS'(1);
    end

    for (int p = 0; p < NUM_PLANES; p++) begin
      if (tag_out.valid && (tag_out.plane == PLANE_BITS'(p))) begin
        if (tag_out.half) begin
          col1_d[p] = mem_rdata;
        end else begin
          col0_d[p] = mem_rdata;
        end
      end
    end

    // A theta arriving mid-sector waits in the single pending slot.
    if (theta_ok && (state_q != IDLE) && !sector_done) begin
      drop_now     = pend_valid_q;
      pend_valid_d = 1'b1;
      pend_theta_d = theta_in;
    end

    case (state_q)
      IDLE: begin
        if (theta_ok) begin
          theta_d     = theta_in;
          row_d       = '0;
          issue_cnt_d = '0;
          state_d     = FETCH;
        end
      end
      FETCH: begin
        if (fetch_done) begin
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (handshake) begin
          issue_cnt_d = '0;
          state_d     = FETCH;
          if (!last_row) begin
            row_d = row_q + ROW_BITS'(1);
          end else begin
            row_d = '0;
            // A theta landing on the final beat becomes the next sector and
            // supersedes anything still pending.
            if (theta_ok) begin
              theta_d      = theta_in;
              drop_now     = pend_valid_q;
              pend_valid_d = 1'b0;
            end else if (pend_valid_q) begin
              theta_d      = pend_theta_q;
              pend_valid_d = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    drop_count_d = drop_count_q;
    if (drop_now && (drop_count_q != 8'hFF)) begin
      drop_count_d = drop_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      theta_q      <= '0;
      pend_theta_q <= '0;
      pend_valid_q <= 1'b0;
      row_q        <= '0;
      issue_cnt_q  <= '0;
      drop_count_q <= '0;
      theta_err_q  <= 1'b0;
      col0_q       <= '0;
      col1_q       <= '0;
    end else begin
      state_q      <= state_d;
      theta_q      <= theta_d;
      pend_theta_q <= pend_theta_d;
      pend_valid_q <= pend_valid_d;
      row_q        <= row_d;
      issue_cnt_q  <= issue_cnt_d;
      drop_count_q <= drop_count_d;
      theta_err_q  <= theta_err_d;
      col0_q       <= col0_d;
      col1_q       <= col1_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hub75_column_fetch.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tb_hub75_column_fetch: self-checking bench for the fetcher     |
// | Revision: 1.0                                                  |
// +----------------------------------------------------------------+
module tb_hub75_column_fetch;
  import hub75_pkg::*;

  localparam int LAT      = 2;
  localparam int TV_DELAY = 19 + LAT;

  logic                  clk_in = 1'b0;
  logic                  rst_in = 1'b0;
  logic [THETA_BITS-1:0] theta_in = '0;
  logic                  theta_valid = 1'b0;
  logic [ADDR_BITS-1:0]  mem_addr;
  logic                  mem_en;
  logic [NUM_COLS-1:0]   mem_rdata;
  column_word_t          column_data0, column_data1;
  logic [ROW_BITS-1:0]   col_index;
  logic                  tvalid;
  logic                  tready = 1'b0;
  logic                  tlast;
  logic                  busy;
  logic [7:0]            drop_count;
  logic                  theta_err;

  hub75_column_fetch #(.BRAM_LATENCY(LAT)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .theta_in     (theta_in),
    .theta_valid  (theta_valid),
    .mem_addr     (mem_addr),
    .mem_en       (mem_en),
    .mem_rdata    (mem_rdata),
    .column_data0 (column_data0),
    .column_data1 (column_data1),
    .col_index    (col_index),
    .tvalid       (tvalid),
    .tready       (tready),
    .tlast        (tlast),
    .busy         (busy),
    .drop_count   (drop_count),
    .theta_err    (theta_err)
  );

  always #5 clk_in = ~clk_in;

  // BRAM contents: low bits echo the address, high bits carry a salt.
  logic [31:0] salt = 32'd0;

  function automatic logic [63:0] bram_word(input logic [ADDR_BITS-1:0] a);
    return {salt, 14'h0, a};
  endfunction

  function automatic column_word_t exp_word(input logic [7:0] th, input int row, input logic half);
    column_word_t w;
    for (int p = 0; p < NUM_PLANES; p++) begin
      w[p] = bram_word({th, ROW_BITS'(row), half, 4'(p)});
    end
    return w;
  endfunction

  logic [ADDR_BITS-1:0] bram_a1;
  logic                 bram_e1;
  always @(posedge clk_in) begin
    bram_a1   <= mem_addr;
    bram_e1   <= mem_en;
    mem_rdata <= bram_e1 ? bram_word(bram_a1) : 64'hDEAD_BEEF_0BAD_F00D;
  end

  int hs_beats = 0;
  int hs_lasts = 0;
  int reads8   = 0;
  always @(posedge clk_in) begin
    if (tvalid && tready) begin
      hs_beats <= hs_beats + 1;
      if (tlast) hs_lasts <= hs_lasts + 1;
    end
    if (mem_en && (mem_addr[ADDR_BITS-1 -: THETA_BITS] == 8'd8)) reads8 <= reads8 + 1;
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_word(input string name, input column_word_t act, input column_word_t exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: sector/beat bookkeeping by the transfer rules.
  logic       m_active = 1'b0;
  logic [7:0] m_theta  = '0;
  int         m_beat   = 0;
  int         m_wait   = 0;
  logic       m_pend_v = 1'b0;
  logic [7:0] m_pend_t = '0;
  int         m_drops  = 0;
  logic       m_err    = 1'b0;

  task automatic m_start(input logic [7:0] t);
    m_active = 1'b1;
    m_theta  = t;
    m_beat   = 0;
    m_wait   = 0;
  endtask

  task automatic m_drop();
    if (m_drops < 255) m_drops++;
  endtask

  task automatic m_clear();
    m_active = 1'b0;
    m_pend_v = 1'b0;
    m_drops  = 0;
    m_err    = 1'b0;
    m_beat   = 0;
    m_wait   = 0;
  endtask

  // One cycle: compare outputs against the model, drive inputs, advance.
  task automatic step(input logic pulse, input logic [7:0] th, input logic rdy);
    logic tv_exp, en_exp, ok, hs, fin;
    int idx;
    logic [ADDR_BITS-1:0] ea;
    tv_exp = m_active && (m_wait >= TV_DELAY);
    en_exp = m_active && (m_wait >= 1) && (m_wait <= READS_PER_ROW);
    chk("busy", busy, m_active);
    chk("tvalid", tvalid, tv_exp);
    chk("mem_en", mem_en, en_exp);
    chk("drop_count", drop_count, m_drops);
    chk("theta_err", theta_err, m_err);
    if (en_exp) begin
      idx = m_wait - 1;
      ea  = {m_theta, ROW_BITS'(m_beat), (idx >= NUM_PLANES), 4'(idx % NUM_PLANES)};
      chk("mem_addr", mem_addr, ea);
    end
    if (tv_exp) begin
      chk("col_index", col_index, m_beat);
      chk("tlast", tlast, (m_beat == SCAN_RATE - 1));
      chk_word("column_data0", column_data0, exp_word(m_theta, m_beat, 1'b0));
      chk_word("column_data1", column_data1, exp_word(m_theta, m_beat, 1'b1));
    end else begin
      chk("tlast_without_tvalid", tlast, 1'b0);
    end

    theta_valid = pulse;
    theta_in    = th;
    tready      = rdy;

    ok  = pulse && (int'(th) < ROTATIONAL_RES);
    hs  = tv_exp && rdy;
    fin = hs && (m_beat == SCAN_RATE - 1);
    if (pulse && !ok) m_err = 1'b1;
    if (hs && !fin) begin
      m_beat++;
      m_wait = 0;
    end else if (fin) begin
      if (ok) begin
        if (m_pend_v) m_drop();
        m_pend_v = 1'b0;
        m_start(th);
      end else if (m_pend_v) begin
        m_pend_v = 1'b0;
        m_start(m_pend_t);
      end else begin
        m_active = 1'b0;
      end
    end
    if (ok && !fin) begin
      if (!m_active) m_start(th);
      else begin
        if (m_pend_v) m_drop();
        m_pend_v = 1'b1;
        m_pend_t = th;
      end
    end

    @(negedge clk_in);
    if (m_active) m_wait++;
    theta_valid = 1'b0;
  endtask

  task automatic run_until_idle(input int max_steps, input int rdy_pct);
    for (int g = 0; g < max_steps && m_active; g++) begin
      step(1'b0, 8'd0, ($urandom_range(0, 99) < rdy_pct));
    end
    chk("busy_after_sector", busy, 1'b0);
  endtask

  task automatic do_reset();
    rst_in      = 1'b1;
    theta_valid = 1'b0;
    theta_in    = '0;
    tready      = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    m_clear();
    @(negedge clk_in);
  endtask

  typedef struct {
    logic [7:0] theta;
    logic       exp_busy;
    logic       exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat, b0, l0, stall;
    logic sent8, sent9, done_b2b, p;
    logic [7:0] th;

    vecs[0] = '{8'd0,   1'b1, 1'b0};
    vecs[1] = '{8'd5,   1'b1, 1'b0};
    vecs[2] = '{8'd100, 1'b1, 1'b0};
    vecs[3] = '{8'd179, 1'b1, 1'b0};
    vecs[4] = '{8'd180, 1'b0, 1'b1};
    vecs[5] = '{8'd255, 1'b0, 1'b1};

    // Asynchronous reset with no clock edge yet.
    #2 rst_in = 1'b1;
    #1;
    chk("reset_tvalid", tvalid, 1'b0);
    chk("reset_tlast", tlast, 1'b0);
    chk("reset_col_index", col_index, 0);
    chk("reset_mem_en", mem_en, 1'b0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_drop_count", drop_count, 0);
    chk("reset_theta_err", theta_err, 1'b0);
    chk_word("reset_column_data0", column_data0, '0);
    chk_word("reset_column_data1", column_data1, '0);
    do_reset();

    // Single pulses from idle: accept range boundaries, reject >= 180.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      step(1'b1, vecs[v].theta, 1'b1);
      for (int k = 0; k < 3; k++) step(1'b0, 8'd0, 1'b1);
      chk("vec_busy", busy, vecs[v].exp_busy);
      chk("vec_theta_err", theta_err, vecs[v].exp_err);
      chk("vec_mem_en", mem_en, vecs[v].exp_busy);
    end

    // Sector 5: first-beat latency and contents, then a 50-cycle stall on beat 3.
    do_reset();
    salt = 32'd0;
    b0 = hs_beats;
    l0 = hs_lasts;
    step(1'b1, 8'd5, 1'b1);
    lat = 1;
    while (tvalid !== 1'b1 && lat < 40) begin
      step(1'b0, 8'd0, 1'b1);
      lat++;
    end
    chk("first_beat_latency", lat, TV_DELAY);
    chk("first_beat_col_index", col_index, 0);
    chk("first_beat_upper_p0", column_data0[0], {46'd0, 8'd5, 5'd0, 1'b0, 4'd0});
    chk("first_beat_lower_p8", column_data1[8], {46'd0, 8'd5, 5'd0, 1'b1, 4'd8});
    stall = 0;
    for (int g = 0; g < 3000 && m_active; g++) begin
      if (m_beat == 3 && m_wait >= TV_DELAY && stall < 50) begin
        stall++;
        step(1'b0, 8'd0, 1'b0);
      end else begin
        step(1'b0, 8'd0, 1'b1);
      end
    end
    chk("stall_cycles", stall, 50);
    chk("beats_per_sector", hs_beats - b0, SCAN_RATE);
    chk("tlast_per_sector", hs_lasts - l0, 1);
    chk("busy_after_sector5", busy, 1'b0);

    // Pulses 7, 8, 9: 8 is overwritten in the pending slot.
    sent8 = 1'b0;
    sent9 = 1'b0;
    step(1'b1, 8'd7, 1'b1);
    for (int g = 0; g < 3000 && m_theta != 8'd9; g++) begin
      p  = 1'b0;
      th = 8'd0;
      if (!sent8 && m_beat == 2) begin p = 1'b1; th = 8'd8; sent8 = 1'b1; end
      else if (!sent9 && m_beat == 5) begin p = 1'b1; th = 8'd9; sent9 = 1'b1; end
      step(p, th, 1'b1);
    end
    chk("drop_after_789", drop_count, 1);

    // Theta 12 lands on sector 9's final handshake.
    done_b2b = 1'b0;
    for (int g = 0; g < 3000 && !done_b2b; g++) begin
      if (m_active && m_wait >= TV_DELAY && m_beat == SCAN_RATE - 1) begin
        step(1'b1, 8'd12, 1'b1);
        done_b2b = 1'b1;
      end else begin
        step(1'b0, 8'd0, 1'b1);
      end
    end
    chk("b2b_busy", busy, 1'b1);
    chk("b2b_mem_en", mem_en, 1'b1);
    chk("b2b_theta", mem_addr[ADDR_BITS-1 -: THETA_BITS], 8'd12);
    chk("b2b_drop_count", drop_count, 1);
    run_until_idle(3000, 100);
    chk("theta8_never_read", reads8, 0);

    // Asynchronous reset mid-FETCH at row 10.
    step(1'b1, 8'd20, 1'b1);
    for (int g = 0; g < 3000 && !(m_beat == 10 && m_wait == 5); g++) step(1'b0, 8'd0, 1'b1);
    chk("pre_reset_col_index", col_index, 10);
    #2 rst_in = 1'b1;
    #1;
    chk("midreset_tvalid", tvalid, 1'b0);
    chk("midreset_mem_en", mem_en, 1'b0);
    chk("midreset_mem_addr", mem_addr, 0);
    chk("midreset_busy", busy, 1'b0);
    chk("midreset_col_index", col_index, 0);
    chk("midreset_drop_count", drop_count, 0);
    chk_word("midreset_column_data0", column_data0, '0);
    chk_word("midreset_column_data1", column_data1, '0);
    @(negedge clk_in);
    rst_in = 1'b0;
    m_clear();
    salt = 32'hA5C3_0F69;
    @(negedge clk_in);
    step(1'b1, 8'd33, 1'b1);
    run_until_idle(6000, 70);

    // Random pulses, invalid thetas and back-pressure.
    do_reset();
    salt = $urandom;
    for (int g = 0; g < 6000; g++) begin
      p  = ($urandom_range(0, 299) == 0);
      th = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(180, 255)) : 8'($urandom_range(0, 179));
      step(p, th, ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
